// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron accumulator slice.
// Contents:
//   IN_W / ACC_W      default term and accumulator widths (must match the adder)
//   ACC_MAX / ACC_MIN signed saturation limits of the accumulator
//   acc_state_e       sequencing FSM states
//   sat_res_t         clamped value plus overflow flag
//   sat_add()         folds the (ACC_W+1)-bit adder result into a clamped ACC_W value
package neuron_pkg;

  localparam int IN_W  = 8;
  localparam int ACC_W = 16;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic [ACC_W-1:0] value;
    logic             ovf;
  } sat_res_t;

  // r is the full-precision sum {carry, sum}. The top two bits disagree only
  // when the true result does not fit in ACC_W bits; r's MSB is then the
  // true sign and selects which rail to clamp to.
  function automatic sat_res_t sat_add(input logic [ACC_W:0] r);
    sat_res_t res;
    res.ovf = r[ACC_W] ^ r[ACC_W-1];
    if (!res.ovf) begin
      res.value = r[ACC_W-1:0];
    end else if (r[ACC_W]) begin
      res.value = ACC_MIN;
    end else begin
      res.value = ACC_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Term-in / frame-sum-out bus of the neuron accumulator.
// Handshake: a transfer happens on a rising clock edge where valid && ready are
// both high. A source holds its valid and payload stable until that edge; a
// sink may change ready at any time. Payload is don't-care while valid is low.
//   in_valid/in_ready/in_data/in_last         upstream term stream
//   out_valid/out_ready/out_data/out_sat/
//   out_len_err                               frame result to activation stage
// Modports: master = upstream producer and downstream consumer (the bench),
//           slave  = the accumulator.
interface neuron_accumulator_if;
  import neuron_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_len_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_len_err
  );

endinterface

// File: rtl/neuron_accumulator_adder.sv
// Neuron datapath adder: signed in1 + signed in2 at full precision.
//   in1   IN1_W-bit signed term
//   in2   IN2_W-bit signed running sum
//   sum   low IN2_W bits of the result
//   carry MSB of the (IN2_W+1)-bit sign-extended result, so {carry,sum} is the
//         exact signed sum
module adder #(
  parameter int IN1_W = 8,
  parameter int IN2_W = 16
) (
  input  logic signed [IN1_W-1:0] in1,
  input  logic signed [IN2_W-1:0] in2,
  output logic signed [IN2_W-1:0] sum,
  output logic                    carry
);

  logic [IN2_W:0] r;

  assign r = {{(IN2_W+1-IN1_W){in1[IN1_W-1]}}, in1} + {in2[IN2_W-1], in2};
  assign {carry, sum} = r;

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: folds a stream of signed terms into a saturating signed
// frame sum and presents it on a valid/ready output.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      neuron_accumulator_if.slave (term stream in, frame result out)
//   state_o  current FSM state, for debug/observation
// A frame closes on in_last or when MAX_TERMS terms have been accepted. While
// the result is held (HOLD) no terms are accepted.
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int MAX_TERMS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  neuron_accumulator_if.slave        bus,
  output acc_state_e                 state_o
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

  acc_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_len_err_q, out_len_err_d;

  logic                    in_ready;
  logic                    out_valid;
  logic                    accept;
  logic                    out_fire;
  logic                    close;
  logic                    at_max;
  logic                    fresh;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    sat_new;
  logic signed [ACC_W-1:0] add_in2;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_carry;
  sat_res_t                clamp;

  // ---------------- datapath ----------------
  // In IDLE the first term starts a fresh frame, so the accumulator, counter
  // and sticky flag are treated as zero regardless of their register value.
  assign fresh   = (state_q == IDLE);
  assign add_in2 = fresh ? '0 : acc_q;

  adder #(
    .IN1_W (IN_W),
    .IN2_W (ACC_W)
  ) u_adder (
    .in1   (bus.in_data),
    .in2   (add_in2),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign clamp    = sat_add({add_carry, add_sum});
  assign cnt_inc  = (fresh ? '0 : cnt_q) + 1'b1;
  assign at_max   = (cnt_inc == CNT_MAX);
  assign sat_new  = (fresh ? 1'b0 : sat_q) | clamp.ovf;

  assign accept   = bus.in_valid && in_ready;
  assign out_fire = out_valid && bus.out_ready;
  assign close    = accept && (bus.in_last || at_max);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = close ? HOLD : ACCUM;
      ACCUM:   if (close) state_d = HOLD;
      HOLD:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  // ---------------- accumulator / result next values ----------------
  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sat_d         = sat_q;
    out_data_d    = out_data_q;
    out_sat_d     = out_sat_q;
    out_len_err_d = out_len_err_q;
    if (accept) begin
      acc_d = clamp.value;
      cnt_d = cnt_inc;
      sat_d = sat_new;
    end
    if (close) begin
      out_data_d    = clamp.value;
      out_sat_d     = sat_new;
      out_len_err_d = at_max && !bus.in_last;
    end
    // accept and out_fire never coincide: accept needs !HOLD, out_fire needs HOLD.
    if (out_fire) begin
      acc_d         = '0;
      cnt_d         = '0;
      sat_d         = 1'b0;
      out_data_d    = '0;
      out_sat_d     = 1'b0;
      out_len_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sat_q         <= sat_d;
      out_data_q    <= out_data_d;
      out_sat_q     <= out_sat_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_len_err = out_len_err_q;
  assign state_o         = state_q;

endmodule
